// File: rtl/mips_mem_pkg.sv
// Shared types and lane helpers for the MIPS load/store unit.
// Op encoding, FSM states, and the byte-lane rules for stores and alignment.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LBU = 4'h1,
    OP_LH  = 4'h2,
    OP_LHU = 4'h3,
    OP_LW  = 4'h4,
    OP_LWL = 4'h5,
    OP_LWR = 4'h6,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DATA,
    ST_WR,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  // Undefined op codes report as errors, exactly like a misaligned access.
  function automatic logic access_error(input logic [3:0] op, input logic [1:0] k);
    case (op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: return 1'b0;
      OP_LH, OP_LHU, OP_SH:                 return k[0];
      OP_LW, OP_SW:                         return |k;
      default:                              return 1'b1;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] k);
    case (op)
      OP_SB:   return 4'b0001 << k;
      OP_SH:   return k[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    case (op)
      OP_SB:   return {4{wdata[7:0]}};
      OP_SH:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load-data extraction: byte/half select with sign or zero
// extension, full word, and the LWL/LWR merge with the old rt value.
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] word,
  input  logic [31:0] rt_old,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  assign byte_sel  = word[{k, 3'b000} +: 8];
  assign half_sel  = k[1] ? word[31:16] : word[15:0];
  // 8*(3-k) equals {~k, 3'b000} for a two-bit k.
  assign lwl_shift = {~k, 3'b000};
  assign lwr_shift = {k, 3'b000};

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    rdata = '0;
    case (op)
      OP_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  rdata = {24'h0, byte_sel};
      OP_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  rdata = {16'h0, half_sel};
      OP_LW:   rdata = word;
      OP_LWL:  rdata = (word << lwl_shift) | (rt_old & ~(32'hFFFF_FFFF << lwl_shift));
      OP_LWR:  rdata = (word >> lwr_shift) | (rt_old & ~(32'hFFFF_FFFF >> lwr_shift));
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Bridges one CPU memory op to one word-wide RAM bus transaction, honouring
// waitrequest and returning extracted/merged load data as a one-cycle response.
module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter bit WORD_ADDR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  lsu_state_t  state;
  logic [3:0]  op_q;
  logic [1:0]  k_q;
  logic [31:0] rt_old_q;
  logic [31:0] word_q;
  logic [31:0] align_rdata;
  logic [31:0] bus_address;

  assign bus_address = WORD_ADDR ? {2'b00, req_addr[31:2]} : {req_addr[31:2], 2'b00};

  lsu_align u_align (
    .op     (op_q),
    .k      (k_q),
    .word   (word_q),
    .rt_old (rt_old_q),
    .rdata  (align_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      op_q           <= '0;
      k_q            <= '0;
      rt_old_q       <= '0;
      word_q         <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            k_q       <= req_addr[1:0];
            rt_old_q  <= req_rt_old;
            if (access_error(req_op, req_addr[1:0])) begin
              state <= ST_ERR;
            end else if (is_load(req_op)) begin
              mem_address    <= bus_address;
              mem_byteenable <= 4'b1111;
              mem_read       <= 1'b1;
              state          <= ST_RD;
            end else begin
              mem_address    <= bus_address;
              mem_byteenable <= store_be(req_op, req_addr[1:0]);
              mem_writedata  <= store_data(req_op, req_wdata);
              mem_write      <= 1'b1;
              state          <= ST_WR;
            end
          end
        end
        // Bus outputs are left untouched while stalled, so they stay stable.
        ST_RD: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          word_q <= mem_readdata;
          state  <= ST_RESP;
        end
        ST_WR: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= is_load(op_q) ? align_rdata : 32'h0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench: directed vector table, a mid-stall reset, then random
// ops checked against a byte-level reference model and a bench-side RAM.
module tb_mips_load_store_unit;
  import mips_mem_pkg::*;

  localparam bit WORD_ADDR = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  mips_load_store_unit #(.WORD_ADDR(WORD_ADDR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rt_old      (req_rt_old),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  int vectors_applied = 0;
  int miscompares = 0;
  logic [31:0] ram [64];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt_old;
    int          stalls;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-level view) ----------------
  function automatic bit op_is_load(input logic [3:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU ||
           op == OP_LW || op == OP_LWL || op == OP_LWR;
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit model_err(input logic [3:0] op, input logic [31:0] addr);
    int size;
    if (!op_is_load(op) && !op_is_store(op)) return 1'b1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) size = 2;
    else if (op == OP_LW || op == OP_SW) size = 4;
    else size = 1;
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word, input logic [31:0] rt_old);
    logic [7:0]  m [4];
    logic [7:0]  r [4];
    logic [15:0] h;
    int k;
    k = int'(addr % 4);
    for (int i = 0; i < 4; i++) begin
      m[i] = word[8*i +: 8];
      r[i] = rt_old[8*i +: 8];
    end
    case (op)
      OP_LB:  return (m[k] >= 8'h80) ? 32'(m[k]) - 32'd256 : 32'(m[k]);
      OP_LBU: return 32'(m[k]);
      OP_LH: begin
        h = {m[k+1], m[k]};
        return (h >= 16'h8000) ? 32'(h) - 32'd65536 : 32'(h);
      end
      OP_LHU: return {16'h0, m[k+1], m[k]};
      OP_LW:  return word;
      OP_LWL: begin
        for (int i = 0; i <= k; i++) r[3-k+i] = m[i];
        return {r[3], r[2], r[1], r[0]};
      end
      OP_LWR: begin
        for (int i = k; i < 4; i++) r[i-k] = m[i];
        return {r[3], r[2], r[1], r[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
    int k;
    k = int'(addr % 4);
    if (op == OP_SB) return 4'(1 << k);
    if (op == OP_SH) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] op, input logic [31:0] wdata);
    if (op == OP_SB) return 32'(wdata[7:0]) * 32'h0101_0101;
    if (op == OP_SH) return 32'(wdata[15:0]) * 32'h0001_0001;
    return wdata;
  endfunction

  // Runs one op end to end, acting as the RAM and checking every cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rt_old, input int stalls, input bit exp_err,
                       input logic [31:0] exp_rdata, input string tag);
    bit ld, st, done, rd_acc;
    int cyc, strobes, stalls_left, exp_lat;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    ld = !exp_err && op_is_load(op);
    st = !exp_err && op_is_store(op);
    exp_lat  = exp_err ? 1 : (st ? 2 + stalls : 3 + stalls);
    exp_addr = WORD_ADDR ? (addr >> 2) : (addr & ~32'h3);
    exp_be   = ld ? 4'hF : model_be(op, addr);
    exp_wd   = model_wd(op, wdata);

    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rt_old = rt_old;
    @(posedge clk);
    cyc = 0; strobes = 0; stalls_left = stalls; rd_acc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      // Garbage on the request port while busy must be ignored.
      req_op     = 4'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_rt_old = $urandom;
      mem_readdata = rd_acc ? ram[addr[7:2]] : $urandom;
      rd_acc = 0;
      if (resp_valid) begin
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_strobes"}, 32'(strobes), (ld || st) ? 32'(stalls + 1) : 32'd0);
        check({tag, "_strobe_off"}, 32'({mem_read, mem_write}), 32'd0);
        req_valid = 1'b0;
        done = 1;
      end else begin
        if (req_ready) check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        if (mem_read || mem_write) begin
          strobes++;
          check({tag, "_rd"}, 32'(mem_read), 32'(ld));
          check({tag, "_wr"}, 32'(mem_write), 32'(st));
          check({tag, "_addr"}, mem_address, exp_addr);
          check({tag, "_be"}, 32'(mem_byteenable), 32'(exp_be));
          if (st) check({tag, "_wdata"}, mem_writedata, exp_wd);
          if (stalls_left > 0) begin
            mem_waitrequest = 1'b1;
            stalls_left--;
          end else begin
            mem_waitrequest = 1'b0;
            if (mem_read) rd_acc = 1;
            if (mem_write && st)
              for (int b = 0; b < 4; b++)
                if (exp_be[b]) ram[addr[7:2]][8*b +: 8] = exp_wd[8*b +: 8];
          end
        end else begin
          mem_waitrequest = 1'($urandom);
        end
        @(posedge clk);
        cyc++;
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] rand_ops [11];
    logic [3:0] op;
    logic [31:0] addr, wdata, rt_old;
    bit err;

    rand_ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW, 4'hE};
    for (int i = 0; i < 64; i++) ram[i] = $urandom;

    // op, addr, wdata, rt_old, stalls, err, rdata
    tbl.push_back('{OP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1'b0, 32'h0});
    tbl.push_back('{OP_SW,  32'h10, 32'h80FF1234, 32'h0,        1, 1'b0, 32'h0});
    tbl.push_back('{OP_LB,  32'h13, 32'h0,        32'h0,        0, 1'b0, 32'hFFFFFF80});
    tbl.push_back('{OP_LBU, 32'h13, 32'h0,        32'h0,        2, 1'b0, 32'h00000080});
    tbl.push_back('{OP_LH,  32'h12, 32'h0,        32'h0,        0, 1'b0, 32'hFFFF80FF});
    tbl.push_back('{OP_LHU, 32'h10, 32'h0,        32'h0,        0, 1'b0, 32'h00001234});
    tbl.push_back('{OP_LW,  32'h10, 32'h0,        32'h0,        3, 1'b0, 32'h80FF1234});
    tbl.push_back('{OP_SB,  32'h11, 32'h000000AB, 32'h0,        0, 1'b0, 32'h0});
    tbl.push_back('{OP_LW,  32'h10, 32'h0,        32'h0,        0, 1'b0, 32'h80FFAB34});
    tbl.push_back('{OP_LH,  32'h11, 32'h0,        32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{OP_SW,  32'h12, 32'h12345678, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{OP_LW,  32'h13, 32'h0,        32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{OP_SH,  32'h13, 32'h0000FFFF, 32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{4'hE,   32'h10, 32'h0,        32'h0,        0, 1'b1, 32'h0});
    tbl.push_back('{OP_SW,  32'h20, 32'h44332211, 32'h0,        0, 1'b0, 32'h0});
    tbl.push_back('{OP_LWL, 32'h21, 32'h0,        32'hAABBCCDD, 0, 1'b0, 32'h2211CCDD});
    tbl.push_back('{OP_LWR, 32'h22, 32'h0,        32'hAABBCCDD, 1, 1'b0, 32'hAABB4433});
    tbl.push_back('{OP_LWL, 32'h23, 32'h0,        32'hAABBCCDD, 0, 1'b0, 32'h44332211});
    tbl.push_back('{OP_LWR, 32'h20, 32'h0,        32'hAABBCCDD, 0, 1'b0, 32'h44332211});
    tbl.push_back('{OP_SH,  32'h22, 32'h0000BEEF, 32'h0,        2, 1'b0, 32'h0});
    tbl.push_back('{OP_LW,  32'h20, 32'h0,        32'h0,        0, 1'b0, 32'hBEEF2211});
    tbl.push_back('{OP_LH,  32'h22, 32'h0,        32'h0,        0, 1'b0, 32'hFFFFBEEF});
    tbl.push_back('{OP_LHU, 32'h22, 32'h0,        32'h0,        0, 1'b0, 32'h0000BEEF});
    tbl.push_back('{OP_LB,  32'h20, 32'h0,        32'h0,        0, 1'b0, 32'h00000011});

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    req_rt_old = '0; mem_readdata = '0; mem_waitrequest = 1'b0;
    #12;
    check("reset_req_ready",  32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_err",   32'(resp_err), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_strobes",    32'({mem_read, mem_write}), 32'd0);
    check("reset_address",    mem_address, 32'd0);
    check("reset_be",         32'(mem_byteenable), 32'd0);
    check("reset_writedata",  mem_writedata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      do_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rt_old, tbl[i].stalls,
            tbl[i].err, tbl[i].rdata, $sformatf("vec%0d", i));

    // Reset asserted mid-read while the RAM stalls: the op is dropped silently.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h40; mem_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_read_before", 32'(mem_read), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_read_dropped", 32'(mem_read), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_after_no_resp", 32'(resp_valid), 32'd0);
      check("rst_after_no_read", 32'(mem_read), 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      op     = rand_ops[$urandom_range(0, 10)];
      addr   = 32'($urandom_range(0, 255));
      wdata  = $urandom;
      rt_old = $urandom;
      err    = model_err(op, addr);
      do_op(op, addr, wdata, rt_old, $urandom_range(0, 3), err,
            (!err && op_is_load(op)) ? model_load(op, addr, ram[addr[7:2]], rt_old) : 32'h0,
            $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
